// File: rtl/fusion_mac.sv
// rtl/fusion_mac.sv - multi-precision lane-packed MAC with a two-stage product/accumulate pipeline.
// A job accepts len beats, each split into 1/2/4 signed/unsigned lanes, and returns one psum.
module fusion_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        mode,
  input  logic              s_in,
  input  logic              s_weight,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  psum,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_cnt;
  logic [1:0]               r_mode;
  logic                     r_s_in;
  logic                     r_s_weight;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         r_prod;
  logic                     r_prod_vld;
  logic                     w_accept;
  logic                     w_last_beat;
  logic [ACC_W:0]           w_sum_ext;
  logic                     w_ovf;
  logic [ACC_W-1:0]         w_acc_nxt;

  // Lanes are zero- or sign-extended into full accumulator width, so the product sum is already sign-extended.
  function automatic logic [ACC_W-1:0] f_lane_sum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [1:0] m,
                                                  input logic sa,
                                                  input logic sb);
    int                      lanes;
    int                      lw;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] ea;
    logic signed [ACC_W-1:0] eb;
    lanes = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    lw    = DATA_W / lanes;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lanes) begin
        ea = '0;
        eb = '0;
        for (int j = 0; j < DATA_W; j++) begin
          if (j < lw) begin
            ea[j] = a[i*lw+j];
            eb[j] = b[i*lw+j];
          end
        end
        if (sa && a[i*lw+lw-1]) ea = ea | ({ACC_W{1'b1}} << lw);
        if (sb && b[i*lw+lw-1]) eb = eb | ({ACC_W{1'b1}} << lw);
        sum = sum + ea * eb;
      end
    end
    return sum;
  endfunction

  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (LEN_W'(r_cnt + 1'b1) == r_len);

  assign w_sum_ext = {r_acc[ACC_W-1], r_acc} + {r_prod[ACC_W-1], r_prod};
  assign w_ovf     = (w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1]);

  always_comb begin
    w_acc_nxt = w_sum_ext[ACC_W-1:0];
    if ((SAT != 0) && w_ovf)
      w_acc_nxt = w_sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_s_in     <= 1'b0;
      r_s_weight <= 1'b0;
      r_acc      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_len      <= len;
        r_mode     <= mode;
        r_s_in     <= s_in;
        r_s_weight <= s_weight;
        r_cnt      <= '0;
        r_acc      <= '0;
        r_prod_vld <= 1'b0;
      end else begin
        r_prod_vld <= w_accept;
        if (w_accept) begin
          r_prod <= f_lane_sum(in, weight, r_mode, r_s_in, r_s_weight);
          r_cnt  <= r_cnt + 1'b1;
        end
        if (r_prod_vld) r_acc <= w_acc_nxt;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    psum      = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (len == '0) ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = (r_cnt < r_len);
        if (w_accept && w_last_beat) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        psum      = r_acc;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fusion_mac.sv
// tb/tb_fusion_mac.sv - directed bench for fusion_mac: wrap instance (ACC_W=32) and saturating instance (ACC_W=24).
// A lane-arithmetic model predicts every psum; a negedge monitor checks both instances each cycle.
module tb_fusion_mac;

  logic        clk;
  logic        rst_n;
  logic        start     [2];
  logic [7:0]  len       [2];
  logic [1:0]  mode      [2];
  logic        s_in      [2];
  logic        s_weight  [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  din       [2];
  logic [7:0]  wt        [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [31:0] psum_a;
  logic [23:0] psum_b;

  int     total = 0;
  int     bad   = 0;
  longint exp_psum [2];
  int     qi[$];
  int     qw[$];

  fusion_mac #(.DATA_W(8), .ACC_W(32), .LEN_W(8), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .len(len[0]), .mode(mode[0]),
    .s_in(s_in[0]), .s_weight(s_weight[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in(din[0]), .weight(wt[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .psum(psum_a), .busy(busy[0])
  );

  fusion_mac #(.DATA_W(8), .ACC_W(24), .LEN_W(8), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .len(len[1]), .mode(mode[1]),
    .s_in(s_in[1]), .s_weight(s_weight[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in(din[1]), .weight(wt[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .psum(psum_b), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint dut_psum(input int k);
    if (k == 0) return longint'($signed(psum_a));
    return longint'($signed(psum_b));
  endfunction

  // Expected job result from lane arithmetic over the queued beats, one accumulator update per beat.
  function automatic longint model(input int aw, input bit sat, input int m, input bit sa, input bit sw);
    int     nl, lw;
    longint acc, s, a, w, lim;
    nl  = (m == 1) ? 2 : (m == 2) ? 4 : 1;
    lw  = 8 / nl;
    acc = 0;
    lim = longint'(1) << (aw - 1);
    foreach (qi[b]) begin
      s = 0;
      for (int i = 0; i < nl; i++) begin
        a = (qi[b] >> (i * lw)) & ((1 << lw) - 1);
        w = (qw[b] >> (i * lw)) & ((1 << lw) - 1);
        if (sa && a >= (1 << (lw - 1))) a -= (1 << lw);
        if (sw && w >= (1 << (lw - 1))) w -= (1 << lw);
        s += a * w;
      end
      acc += s;
      if (sat) begin
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim) acc = -lim;
      end else begin
        acc = acc & (2 * lim - 1);
        if (acc >= lim) acc -= 2 * lim;
      end
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) chk($sformatf("mon_psum%0d", k), dut_psum(k), exp_psum[k]);
        else              chk($sformatf("mon_zero%0d", k), dut_psum(k), 0);
      end
    end
  end

  // Called at a negedge with the instance idle; runs one whole job from start to result handshake.
  task automatic run_job(input int k, input int m, input bit sa, input bit sw, input int aw, input bit sat,
                         input longint lit, input bit gaps, input int hold, input bit poke);
    int n;
    int cnt;
    int guard;
    bit acc_now;
    n   = qi.size();
    cnt = 0;
    exp_psum[k] = model(aw, sat, m, sa, sw);
    chk("model_vs_literal", exp_psum[k], lit);
    start[k] = 1'b1; len[k] = 8'(n); mode[k] = 2'(m); s_in[k] = sa; s_weight[k] = sw;
    @(negedge clk);
    start[k] = 1'b0; mode[k] = ~mode[k]; s_in[k] = ~sa; s_weight[k] = ~sw; len[k] = 8'hAA;
    chk("busy_after_start", busy[k], 1);
    guard = 0;
    while (cnt < n) begin
      if (gaps && (guard % 3 == 1)) begin
        in_valid[k] = 1'b0; din[k] = 8'($urandom); wt[k] = 8'($urandom);
      end else begin
        in_valid[k] = 1'b1; din[k] = 8'(qi[cnt]); wt[k] = 8'(qw[cnt]);
      end
      acc_now = in_valid[k] && in_ready[k];
      @(negedge clk);
      if (acc_now) cnt++;
      guard++;
      if (guard > 2000) begin
        chk("beat_timeout", 0, 1);
        in_valid[k] = 1'b0;
        return;
      end
    end
    in_valid[k] = 1'b0; din[k] = 8'($urandom); wt[k] = 8'($urandom);
    chk("drain_no_valid", out_valid[k], 0);
    chk("drain_no_ready", in_ready[k], 0);
    @(negedge clk);
    chk("result_latency", out_valid[k], 1);
    chk("psum_literal", dut_psum(k), lit);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin start[k] = 1'b1; len[k] = 8'd3; mode[k] = 2'b01; end
      @(negedge clk);
      start[k] = 1'b0;
      chk("held_valid", out_valid[k], 1);
      chk("held_psum", dut_psum(k), lit);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("idle_after_ack", out_valid[k], 0);
    chk("busy_after_ack", busy[k], 0);
  endtask

  task automatic set_beats(input int n, input int a, input int w);
    qi.delete(); qw.delete();
    for (int i = 0; i < n; i++) begin qi.push_back(a); qw.push_back(w); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 0; len[k] = 0; mode[k] = 0; s_in[k] = 0; s_weight[k] = 0;
      in_valid[k] = 0; din[k] = 0; wt[k] = 0; out_ready[k] = 0;
      exp_psum[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_psum", dut_psum(k), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    qi = '{8'hFF, 8'h02}; qw = '{8'hFF, 8'h03};
    run_job(0, 0, 0, 0, 32, 0, 65031, 0, 0, 0);
    qi = '{8'h87}; qw = '{8'h87};
    run_job(0, 1, 1, 1, 32, 0, 113, 0, 0, 0);
    qi = '{8'hFF}; qw = '{8'h55};
    run_job(0, 2, 1, 0, 32, 0, -4, 0, 0, 0);
    qi.delete(); qw.delete();
    run_job(0, 0, 0, 0, 32, 0, 0, 0, 0, 0);
    qi = '{8'h80, 8'hFF}; qw = '{8'h7F, 8'hFF};
    run_job(0, 3, 1, 1, 32, 0, -16255, 1, 0, 0);
    qi = '{8'hF3}; qw = '{8'h9E};
    run_job(0, 1, 0, 1, 32, 0, -111, 1, 2, 0);

    set_beats(255, 8'hFF, 8'hFF);
    run_job(1, 0, 0, 0, 24, 1, 64'h7FFFFF, 0, 3, 1);

    exp_psum[0] = 0;
    start[0] = 1'b1; len[0] = 8'd5; mode[0] = 2'b00; s_in[0] = 0; s_weight[0] = 0;
    @(negedge clk);
    start[0] = 1'b0;
    in_valid[0] = 1'b1; din[0] = 8'h11; wt[0] = 8'h22;
    repeat (2) @(negedge clk);
    chk("mid_accum_ready", in_ready[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", in_ready[0], 0);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_valid", out_valid[0], 0);
    chk("async_rst_psum", dut_psum(0), 0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_hold_busy", busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    qi = '{8'h03}; qw = '{8'h04};
    run_job(0, 0, 0, 0, 32, 0, 12, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
